uart_tx_buffer: RTL and testbench

//  Memory-mapped transmit FIFO between the core data bus and simpleuart's data register.
//  The core writes bytes at full bus speed; the block drains them into the UART one at a time,

---
 rtl/uart_tx_buffer.sv | 160 ++++++++++++++++
 tb/tb_uart_tx_buffer.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_buffer.sv
// Transmit FIFO between the core bus and simpleuart's data register; drains one byte at a time.
// Optional drained-interrupt logic is enabled by defining UART_TXBUF_IRQ_EN.
module uart_tx_buffer #(
    parameter int unsigned DEPTH = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [3:0]  addr_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    output logic        uart_we_o,
    output logic [7:0]  uart_dat_o,
    input  logic        uart_wait_i,
    output logic        irq_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
    localparam logic [CW-1:0] ONE_C  = CW'(1);

    typedef enum logic {
        S_IDLE,
        S_OFFER
    } state_e;

    state_e          state_q, state_d;
    logic [7:0]      mem [DEPTH];
    logic [PW-1:0]   head_q, tail_q, head_nxt;
    logic [CW-1:0]   count_q, count_d;
    logic            ovf_q;
    logic [7:0]      dat_d;
    logic [31:0]     rd_val, status, ctrl_val;
    logic [7:0]      cnt8;
    logic            wr_data, wr_status, rd_req;
    logic            full, empty, pop, push_ok, ovf_event;
    logic            unused_wdata;

    assign unused_wdata = ^wdata_i[31:8];

    assign wr_data   = req_i & we_i & (addr_i == 4'h0);
    assign wr_status = req_i & we_i & (addr_i == 4'h4);
    assign rd_req    = req_i & ~we_i;

    assign full      = (count_q == FULL_C);
    assign empty     = (count_q == '0);
    assign pop       = (state_q == S_OFFER) & ~uart_wait_i;
    assign push_ok   = wr_data & (~full | pop);
    assign ovf_event = wr_data & ~push_ok;
    assign head_nxt  = head_q + PW'(1);
    assign uart_we_o = (state_q == S_OFFER);

    always_comb begin
        count_d = count_q;
        if (push_ok && !pop) begin
            count_d = count_q + ONE_C;
        end else if (pop && !push_ok) begin
            count_d = count_q - ONE_C;
        end
    end

    // With one byte left and a same-cycle push, the next byte is still on the bus, not in mem.
    always_comb begin
        state_d = state_q;
        dat_d   = uart_dat_o;
        unique case (state_q)
            S_IDLE: begin
                if (!empty) begin
                    dat_d   = mem[head_q];
                    state_d = S_OFFER;
                end
            end
            S_OFFER: begin
                if (pop) begin
                    if (count_d != '0) begin
                        dat_d = (count_q == ONE_C) ? wdata_i[7:0] : mem[head_nxt];
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign cnt8   = 8'(count_q);
    assign status = {16'h0, cnt8, 4'h0, ovf_q, (state_q == S_OFFER), full, empty};

    always_comb begin
        rd_val = '0;
        case (addr_i)
            4'h4:    rd_val = status;
            4'h8:    rd_val = ctrl_val;
            default: rd_val = '0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem[tail_q] <= wdata_i[7:0];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            ovf_q      <= 1'b0;
            uart_dat_o <= '0;
            rdata_o    <= '0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            uart_dat_o <= dat_d;
            if (pop) begin
                head_q <= head_nxt;
            end
            if (push_ok) begin
                tail_q <= tail_q + PW'(1);
            end
            if (ovf_event) begin
                ovf_q <= 1'b1;
            end else if (wr_status && wdata_i[3]) begin
                ovf_q <= 1'b0;
            end
            if (rd_req) begin
                rdata_o <= rd_val;
            end
        end
    end

`ifdef UART_TXBUF_IRQ_EN
    logic irq_en_q, irq_q;
    logic wr_ctrl;

    assign wr_ctrl  = req_i & we_i & (addr_i == 4'h8);
    assign ctrl_val = {31'h0, irq_en_q};
    assign irq_o    = irq_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            irq_en_q <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            if (wr_ctrl) begin
                irq_en_q <= wdata_i[0];
            end
            irq_q <= irq_en_q & empty & (state_q == S_IDLE);
        end
    end
`else
    assign ctrl_val = '0;
    assign irq_o    = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_buffer.sv
// Directed bench for uart_tx_buffer: vector table for single-cycle behaviour, hand sequences for
// fill/overflow/drain, push-during-pop on full, drained interrupt and asynchronous reset.
module tb_uart_tx_buffer;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        req_i = 1'b0;
    logic        we_i = 1'b0;
    logic [3:0]  addr_i = '0;
    logic [31:0] wdata_i = '0;
    logic [31:0] rdata_o;
    logic        uart_we_o;
    logic [7:0]  uart_dat_o;
    logic        uart_wait_i = 1'b0;
    logic        irq_o;

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] rx[$];

    uart_tx_buffer #(.DEPTH(16)) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .req_i      (req_i),
        .we_i       (we_i),
        .addr_i     (addr_i),
        .wdata_i    (wdata_i),
        .rdata_o    (rdata_o),
        .uart_we_o  (uart_we_o),
        .uart_dat_o (uart_dat_o),
        .uart_wait_i(uart_wait_i),
        .irq_o      (irq_o)
    );

    always #5 clk_i = ~clk_i;

    // UART side: a byte is taken whenever it is offered and the UART is not busy
    always @(negedge clk_i) begin
        if (!rst_i && uart_we_o && !uart_wait_i) rx.push_back(uart_dat_o);
    end

    typedef struct {
        logic        req;
        logic        we;
        logic [3:0]  addr;
        logic [31:0] wdata;
        logic        wt;
        logic [31:0] exp_rdata;
        logic        exp_we;
        logic [7:0]  exp_dat;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(logic req, logic we, logic [3:0] addr, logic [31:0] wdata, logic wt,
                                logic [31:0] er, logic ew, logic [7:0] ed);
        vec_t v;
        v.req = req; v.we = we; v.addr = addr; v.wdata = wdata; v.wt = wt;
        v.exp_rdata = er; v.exp_we = ew; v.exp_dat = ed;
        vecs.push_back(v);
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_bus();
        req_i = 1'b0; we_i = 1'b0; addr_i = '0; wdata_i = '0;
    endtask

    task automatic bus_write(logic [3:0] a, logic [31:0] d);
        req_i = 1'b1; we_i = 1'b1; addr_i = a; wdata_i = d;
        cycle();
        idle_bus();
    endtask

    task automatic check_read(string name, logic [3:0] a, logic [31:0] exp);
        req_i = 1'b1; we_i = 1'b0; addr_i = a; wdata_i = '0;
        cycle();
        idle_bus();
        chk(name, rdata_o, exp);
    endtask

    initial begin
        logic [31:0] irq_after_table;
        bit          seen;

        //  req  we addr  wdata        wt  rdata        we  dat
        add(1, 0, 4'h4, 32'h0,        0, 32'h00000001, 0, 8'h00);
        add(1, 1, 4'h0, 32'h41,       0, 32'h00000001, 0, 8'h00);
        add(0, 0, 4'h0, 32'h0,        0, 32'h00000001, 1, 8'h41);
        add(1, 0, 4'h4, 32'h0,        0, 32'h00000104, 0, 8'h41);
        add(1, 0, 4'h4, 32'h0,        0, 32'h00000001, 0, 8'h41);
        add(1, 0, 4'h0, 32'h0,        0, 32'h00000000, 0, 8'h41);
        add(1, 0, 4'h4, 32'h0,        0, 32'h00000001, 0, 8'h41);
        add(1, 0, 4'h8, 32'h0,        0, 32'h00000000, 0, 8'h41);
        add(1, 0, 4'h4, 32'h0,        0, 32'h00000001, 0, 8'h41);
        add(1, 0, 4'hC, 32'h0,        0, 32'h00000000, 0, 8'h41);
        add(1, 1, 4'h0, 32'h5A,       1, 32'h00000000, 0, 8'h41);
        add(0, 0, 4'h0, 32'h0,        1, 32'h00000000, 1, 8'h5A);
        add(1, 0, 4'h4, 32'h0,        1, 32'h00000104, 1, 8'h5A);
        add(1, 1, 4'h8, 32'h1,        1, 32'h00000104, 1, 8'h5A);
        add(1, 1, 4'hC, 32'hFF,       1, 32'h00000104, 1, 8'h5A);
        add(0, 0, 4'h0, 32'h0,        0, 32'h00000104, 0, 8'h5A);
        add(1, 1, 4'h4, 32'hFFFFFFFF, 0, 32'h00000104, 0, 8'h5A);
        add(1, 1, 4'h0, 32'h01,       0, 32'h00000104, 0, 8'h5A);
        add(1, 1, 4'h0, 32'h02,       0, 32'h00000104, 1, 8'h01);
        add(0, 0, 4'h0, 32'h0,        0, 32'h00000104, 1, 8'h02);
        add(0, 0, 4'h0, 32'h0,        0, 32'h00000104, 0, 8'h02);
        add(1, 1, 4'h0, 32'h03,       0, 32'h00000104, 0, 8'h02);
        add(0, 0, 4'h0, 32'h0,        0, 32'h00000104, 1, 8'h03);
        add(1, 1, 4'h0, 32'h04,       0, 32'h00000104, 1, 8'h04);
        add(0, 0, 4'h0, 32'h0,        0, 32'h00000104, 0, 8'h04);
        add(1, 0, 4'h4, 32'h0,        0, 32'h00000001, 0, 8'h04);

        cycle();
        chk("reset_rdata", rdata_o, 32'h0);
        chk("reset_uart_we", {31'h0, uart_we_o}, 32'h0);
        chk("reset_uart_dat", {24'h0, uart_dat_o}, 32'h0);
        chk("reset_irq", {31'h0, irq_o}, 32'h0);
        rst_i = 1'b0;
        cycle();

        foreach (vecs[i]) begin
            req_i = vecs[i].req; we_i = vecs[i].we; addr_i = vecs[i].addr;
            wdata_i = vecs[i].wdata; uart_wait_i = vecs[i].wt;
            cycle();
            chk($sformatf("vec%0d_rdata", i), rdata_o, vecs[i].exp_rdata);
            chk($sformatf("vec%0d_uart_we", i), {31'h0, uart_we_o}, {31'h0, vecs[i].exp_we});
            chk($sformatf("vec%0d_uart_dat", i), {24'h0, uart_dat_o}, {24'h0, vecs[i].exp_dat});
        end
        idle_bus();
        uart_wait_i = 1'b0;
`ifdef UART_TXBUF_IRQ_EN
        irq_after_table = 32'h1;
`else
        irq_after_table = 32'h0;
`endif
        chk("irq_after_table", {31'h0, irq_o}, irq_after_table);

        // Fill while the UART is busy, overflow on the 17th byte, then drain in order
        rx.delete();
        uart_wait_i = 1'b1;
        for (int i = 0; i < 16; i++) bus_write(4'h0, 32'h10 + i);
        check_read("full_status", 4'h4, 32'h00001006);
        bus_write(4'h0, 32'h55);
        check_read("ovf_status", 4'h4, 32'h0000100E);
        uart_wait_i = 1'b0;
        repeat (24) cycle();
        chk("drain1_count", rx.size(), 16);
        for (int i = 0; i < 16; i++)
            chk($sformatf("drain1_byte%0d", i), (i < rx.size()) ? {24'h0, rx[i]} : 32'hFFFF, 32'h10 + i);
        check_read("drained_ovf_status", 4'h4, 32'h00000009);

        // Overflow clear, then set again by a push on a full FIFO
        bus_write(4'h4, 32'h8);
        check_read("ovf_cleared", 4'h4, 32'h00000001);
        rx.delete();
        uart_wait_i = 1'b1;
        for (int i = 0; i < 16; i++) bus_write(4'h0, 32'h20 + i);
        bus_write(4'h0, 32'h66);
        check_read("ovf_again", 4'h4, 32'h0000100E);
        bus_write(4'h4, 32'h8);
        check_read("ovf_cleared_full", 4'h4, 32'h00001006);

        // Push on full accepted because a pop completes in the same cycle
        req_i = 1'b1; we_i = 1'b1; addr_i = 4'h0; wdata_i = 32'hAA; uart_wait_i = 1'b0;
        cycle();
        idle_bus();
        uart_wait_i = 1'b1;
        check_read("push_pop_full", 4'h4, 32'h00001006);
        uart_wait_i = 1'b0;
        repeat (24) cycle();
        chk("drain2_count", rx.size(), 17);
        for (int i = 0; i < 16; i++)
            chk($sformatf("drain2_byte%0d", i), (i < rx.size()) ? {24'h0, rx[i]} : 32'hFFFF, 32'h20 + i);
        chk("drain2_last", (rx.size() > 16) ? {24'h0, rx[16]} : 32'hFFFF, 32'hAA);
        check_read("drain2_status", 4'h4, 32'h00000001);

`ifdef UART_TXBUF_IRQ_EN
        bus_write(4'h8, 32'h1);
        check_read("ctrl_read", 4'h8, 32'h1);
        uart_wait_i = 1'b0;
        bus_write(4'h0, 32'h01);
        bus_write(4'h0, 32'h02);
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            cycle();
            if (!uart_we_o) seen = 1'b1;
        end
        chk("irq_drain_seen", {31'h0, seen}, 32'h1);
        chk("irq_not_early", {31'h0, irq_o}, 32'h0);
        cycle();
        chk("irq_rise", {31'h0, irq_o}, 32'h1);
`else
        bus_write(4'h8, 32'h1);
        check_read("ctrl_read_disabled", 4'h8, 32'h0);
        chk("irq_tied_low", {31'h0, irq_o}, 32'h0);
`endif

        // Asynchronous reset while a byte is being offered
        uart_wait_i = 1'b1;
        bus_write(4'h0, 32'h31);
        bus_write(4'h0, 32'h32);
        bus_write(4'h0, 32'h33);
        check_read("pre_reset_status", 4'h4, 32'h00000304);
        chk("pre_reset_we", {31'h0, uart_we_o}, 32'h1);
        #2 rst_i = 1'b1;
        #1;
        chk("async_rst_we", {31'h0, uart_we_o}, 32'h0);
        chk("async_rst_dat", {24'h0, uart_dat_o}, 32'h0);
        chk("async_rst_rdata", rdata_o, 32'h0);
        chk("async_rst_irq", {31'h0, irq_o}, 32'h0);
        cycle();
        rst_i = 1'b0;
        rx.delete();
        uart_wait_i = 1'b0;
        repeat (5) cycle();
        chk("no_retransmit", rx.size(), 0);
        check_read("post_reset_status", 4'h4, 32'h00000001);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
